// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port and the unified memory.
// The arbiter takes the slave view; the surrounding pipeline/memory take master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port has priority, fetch is guaranteed one
// win after STARVE_MAX denied cycles; read responses are steered by an owner tag.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halted,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_gnt, dm_gnt;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    owner_d  = OWN_NONE;
    starve_d = starve_q;
    addr_mux = bus.dm_addr;

    // Fetch only beats a pending data request once it has been starved long enough.
    if (!rst) begin
      if_gnt = bus.if_req && !halted && (!bus.dm_req || starve_q == STARVE_LIM);
      dm_gnt = bus.dm_req && !if_gnt;
    end

    if (if_gnt) begin
      addr_mux = bus.if_addr;
      owner_d  = OWN_IF;
    end else if (dm_gnt && !bus.dm_we) begin
      owner_d  = OWN_DM;
    end

    // Halt freezes the starvation count so the guarantee survives a stall.
    if (!halted) begin
      if (!bus.if_req || if_gnt) begin
        starve_d = 4'd0;
      end else if (starve_q < STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    rdata         = bus.mem_rdata;
    bus.if_gnt    = if_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.mem_en    = if_gnt || dm_gnt;
    bus.mem_we    = dm_gnt && bus.dm_we;
    bus.mem_addr  = addr_mux;
    bus.mem_wdata = bus.dm_wdata;
    bus.if_rvalid = (owner_q == OWN_IF) && !rst;
    bus.dm_rvalid = (owner_q == OWN_DM) && !rst;
    bus.if_rdata  = rdata;
    bus.dm_rdata  = rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .halted(halted),
    .bus(bus)
  );

  // Unified memory with a one-cycle synchronous read port.
  bit [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (rst) bus.mem_rdata <= '0;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who should win, which reply is owed, and what it carries.
  int              m_starve = 0;
  int              m_pend   = 0;
  bit [DATA_W-1:0] m_pend_data;
  bit [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  bit              e_if, e_dm, e_rv_if, e_rv_dm;
  bit              last_if_gnt, last_dm_gnt;
  string           dut_trace = "";
  string           mdl_trace = "";

  always @(negedge clk) begin
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rst) begin
      if (bus.if_req && !halted && (!bus.dm_req || m_starve == STARVE_MAX)) e_if = 1'b1;
      else if (bus.dm_req) e_dm = 1'b1;
    end
    e_rv_if = !rst && m_pend == 1;
    e_rv_dm = !rst && m_pend == 2;

    checkOutput("if_gnt", bus.if_gnt, e_if);
    checkOutput("dm_gnt", bus.dm_gnt, e_dm);
    checkOutput("mem_en", bus.mem_en, e_if || e_dm);
    checkOutput("mem_we", bus.mem_we, e_dm && bus.dm_we);
    checkOutput("if_rvalid", bus.if_rvalid, e_rv_if);
    checkOutput("dm_rvalid", bus.dm_rvalid, e_rv_dm);
    if (e_if) checkOutput("mem_addr_if", bus.mem_addr, bus.if_addr);
    if (e_dm) checkOutput("mem_addr_dm", bus.mem_addr, bus.dm_addr);
    if (e_dm && bus.dm_we) checkOutput("mem_wdata", bus.mem_wdata, bus.dm_wdata);
    if (e_rv_if) checkOutput("if_rdata", bus.if_rdata, m_pend_data);
    if (e_rv_dm) checkOutput("dm_rdata", bus.dm_rdata, m_pend_data);

    dut_trace = {dut_trace, bus.if_gnt ? "I" : (bus.dm_gnt ? "D" : "-")};
    mdl_trace = {mdl_trace, e_if ? "I" : (e_dm ? "D" : "-")};

    m_pend = 0;
    if (e_if) begin
      m_pend = 1;
      m_pend_data = ref_mem[bus.if_addr];
    end else if (e_dm && !bus.dm_we) begin
      m_pend = 2;
      m_pend_data = ref_mem[bus.dm_addr];
    end
    if (e_dm && bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;

    if (rst) m_starve = 0;
    else if (!halted) begin
      if (!bus.if_req || e_if) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end
    last_if_gnt = e_if;
    last_dm_gnt = e_dm;
  end

  task automatic applyStimulus(input logic r, input logic h, input logic ir,
                               input logic [ADDR_W-1:0] ia, input logic dr,
                               input logic dw, input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] dd);
    @(posedge clk);
    #1;
    rst          = r;
    halted       = h;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    settle();
  endtask

  int base;
  logic ir, dr, dw, hv, rv;
  logic [ADDR_W-1:0] ia, da;
  logic [DATA_W-1:0] dd;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
    bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checkOutput("rst_if_gnt", bus.if_gnt, 1'b0);
      checkOutput("rst_dm_gnt", bus.dm_gnt, 1'b0);
      checkOutput("rst_mem_en", bus.mem_en, 1'b0);
      checkOutput("rst_mem_we", bus.mem_we, 1'b0);
      checkOutput("rst_if_rvalid", bus.if_rvalid, 1'b0);
      checkOutput("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
      checkOutput("rst_mem_addr", bus.mem_addr, 0);
      checkOutput("rst_if_rdata", bus.if_rdata, 0);
    end
    idle(1'b0);
    checkOutput("post_rst_if_rvalid", bus.if_rvalid, 1'b0);
    checkOutput("post_rst_dm_rvalid", bus.dm_rvalid, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 10'd5, 32'h00A00093);
    settle();
    checkOutput("preload_we", bus.mem_we, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("fetch_gnt", bus.if_gnt, 1'b1);
    checkOutput("fetch_mem_en", bus.mem_en, 1'b1);
    checkOutput("fetch_mem_addr", bus.mem_addr, 10'd5);
    idle(1'b0);
    checkOutput("fetch_rvalid", bus.if_rvalid, 1'b1);
    checkOutput("fetch_rdata", bus.if_rdata, 32'h00A00093);
    checkOutput("fetch_dm_rvalid", bus.dm_rvalid, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 10'd10, 32'hDEADBEEF);
    settle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 10'd10, '0);
    settle();
    checkOutput("store_no_rvalid", bus.dm_rvalid, 1'b0);
    idle(1'b0);
    checkOutput("load_rvalid", bus.dm_rvalid, 1'b1);
    checkOutput("load_rdata", bus.dm_rdata, 32'hDEADBEEF);

    base = dut_trace.len();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd10, '0);
      settle();
    end
    checkOutput("contention_dut", (dut_trace.substr(base, base + 11) == "DDDIDDDIDDDI"), 1'b1);
    checkOutput("contention_model", (mdl_trace.substr(base, base + 11) == "DDDIDDDIDDDI"), 1'b1);
    idle(1'b0);

    base = dut_trace.len();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, (i >= 2 && i < 7), 1'b1, 10'd5, 1'b1, 1'b0, 10'd10, '0);
      settle();
    end
    checkOutput("halt_dut", (dut_trace.substr(base, base + 8) == "DDDDDDDDI"), 1'b1);
    checkOutput("halt_model", (mdl_trace.substr(base, base + 8) == "DDDDDDDDI"), 1'b1);
    idle(1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("pre_rst_gnt", bus.if_gnt, 1'b1);
    idle(1'b1);
    checkOutput("drop_rvalid_n1", bus.if_rvalid, 1'b0);
    idle(1'b0);
    checkOutput("drop_rvalid_n2", bus.if_rvalid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0);
    settle();
    checkOutput("resume_gnt", bus.if_gnt, 1'b1);
    idle(1'b0);
    checkOutput("resume_rdata", bus.if_rdata, 32'h00A00093);

    applyStimulus(1'b1, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd10, '0);
    settle();
    checkOutput("rst_grant_if", bus.if_gnt, 1'b0);
    checkOutput("rst_grant_dm", bus.dm_gnt, 1'b0);
    checkOutput("rst_grant_en", bus.mem_en, 1'b0);
    idle(1'b0);
    checkOutput("rst_grant_rvalid", bus.if_rvalid || bus.dm_rvalid, 1'b0);

    // Random traffic: requesters hold their request until the model says it was taken.
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0; hv = 1'b0; rv = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(ir && !last_if_gnt)) begin
        ir = ($urandom_range(2) != 0);
        ia = ADDR_W'($urandom_range(15));
      end
      if (!(dr && !last_dm_gnt)) begin
        dr = ($urandom_range(2) != 0);
        dw = $urandom_range(1) != 0;
        da = ADDR_W'($urandom_range(15));
        dd = DATA_W'($urandom);
      end
      if ($urandom_range(9) == 0) hv = !hv;
      rv = ($urandom_range(99) < 2);
      applyStimulus(rv, hv, ir, ia, dr, dw, da, dd);
      settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch port and its load/store (data) port. The core keeps one unified word-addressed memory for both code and data, so this block issues at most one memory access per cycle. It resolves fetch/data contention with data priority plus a fetch-starvation guard, and it routes each read response back to the port that requested it. The block sits between the IF/EX stages and the memory array, and it honours the core's HALTED signal.

## Interface
- ADDR_W, 10, word address width (memory depth 2^ADDR_W words)
- DATA_W, 32, word width
- STARVE_MAX, 3, consecutive denied fetch cycles after which fetch wins once; legal range 1..15
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  core halted; while 1, no fetch grants are issued
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid (loads only)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after mem_en with mem_we = 0

## Operation
- Requesters hold req, address, and write data stable until gnt is seen. The arbiter never grants both ports in one cycle.
- Grants are combinational in the request cycle. The granted port's addr, we, and wdata drive mem_* in the same cycle, with mem_en = 1. With no grant, mem_en = 0 and mem_we = 0.
- Arbitration:
  - dm_req alone → dm_gnt.
  - if_req alone and !halted → if_gnt.
  - Both asserted and !halted: fetch wins only if starve_cnt == STARVE_MAX; otherwise data wins.
  - halted = 1 → if_gnt = 0 regardless; data requests are still served.
- starve_cnt (4-bit) rules:
  - Increments by 1 each cycle that if_req = 1, !halted, and if_gnt = 0.
  - Saturates at STARVE_MAX.
  - Clears to 0 on if_gnt, or when if_req = 0.
  - Holds its value while halted = 1.
- Response routing uses a registered owner tag:
  - States: NONE, IF, DM.
  - The next owner is IF on if_gnt; DM on dm_gnt with dm_we = 0; NONE otherwise (including store grants).
  - owner == IF → if_rvalid = 1. owner == DM → dm_rvalid = 1.
- if_rdata and dm_rdata both carry mem_rdata. Consumers qualify the data with rvalid.
- Stores produce no rvalid. Back-to-back store then load to the same address returns the stored word; the memory handles write-before-read across cycles.

## Timing
- Reset values: owner = NONE, starve_cnt = 0. Hence if_rvalid = 0 and dm_rvalid = 0 on the first cycle after rst.
- While rst = 1, all grants and mem_en are forced to 0.
- Read latency: grant at cycle N → rvalid with data at cycle N+1. Throughput is one access per cycle with no bubble between grants.
- Reset asserted in the cycle after a grant: the pending response is dropped, and rvalid stays 0.
- Reset asserted in the grant cycle itself: the grant is suppressed, and no memory access occurs.
- Simultaneous requests with data continuously active: the pattern is STARVE_MAX data grants, then 1 fetch grant, repeating.
- Halt rising while a fetch response is pending: that response still returns at N+1. halted gates only new grants.
- Address width: addresses are used as-is; there is no wrap or bounds check.

## Test plan
- Reset with all requests 0 → every output 0 for 3 cycles. No rvalid in the cycle after rst deasserts.
- Preload mem[5] = 0x00A00093. if_req with if_addr = 5 at cycle N → if_gnt = 1, mem_en = 1, and mem_addr = 5 at N. At N+1, if_rvalid = 1 and if_rdata = 0x00A00093; dm_rvalid = 0.
- dm store to address 10 with 0xDEADBEEF at N, then a load from 10 at N+1 → no rvalid at N+1; dm_rvalid = 1 with 0xDEADBEEF at N+2.
- if_req and dm_req (loads) both held high for 12 cycles, STARVE_MAX = 3 → grant sequence D,D,D,I repeating three times. Each rvalid lands one cycle after its grant on the correct port.
- halted = 1 for 5 cycles with if_req and dm_req high → only dm_gnt is issued, and starve_cnt holds. After halted falls, fetch is granted as soon as starve_cnt reaches STARVE_MAX.
- if_gnt at cycle N with rst = 1 at N+1 → if_rvalid = 0 at N+1 and N+2. Normal fetch service resumes after rst falls.
